// File: rtl/loba_div_16_4.sv
// Leading-one truncated-divisor sequential divider (approximate a / b).
// Ports: clk, rst_n (async low); in_valid/in_ready + a, b request side;
//        out_valid/out_ready + q (quotient), dz (divide-by-zero) result side.
module loba_div_16_4 #(
    parameter int N = 16,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] q,
    output logic         dz
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        SPLIT,
        DIV,
        DONE
    } state_t;

    state_t        state;
    logic [N-1:0]  a_r;
    logic [N-1:0]  b_r;
    logic [N-1:0]  bt_r;
    logic [N-1:0]  rem;
    logic [CW-1:0] cnt;

    logic [CW-1:0] kb;
    logic [N-1:0]  bt_c;
    logic [N:0]    shifted;
    logic          ge;
    logic [N-1:0]  rem_nx;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Leading-one index of b, then keep only the K bits from it downward.
    always_comb begin
        kb = '0;
        for (int i = 0; i < N; i++) begin
            if (b_r[i]) kb = CW'(i);
        end
        bt_c = '0;
        for (int i = 0; i < N; i++) begin
            bt_c[i] = b_r[i] & ((i + K) > int'(kb));
        end
    end

    // Restoring step. The partial remainder is N+1 bits wide before the
    // compare; after a successful subtract it is below bt, so N bits hold it
    // and the modulo-2^N subtraction is exact.
    always_comb begin
        shifted = {rem, a_r[N-1]};
        ge      = (shifted >= {1'b0, bt_r});
        rem_nx  = ge ? (shifted[N-1:0] - bt_r) : shifted[N-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            bt_r  <= '0;
            rem   <= '0;
            cnt   <= '0;
            q     <= '0;
            dz    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b;
                        state <= SPLIT;
                    end
                end
                SPLIT: begin
                    bt_r <= bt_c;
                    if (b_r == '0) begin
                        q     <= '1;
                        dz    <= 1'b1;
                        state <= DONE;
                    end else begin
                        rem   <= '0;
                        cnt   <= CW'(N - 1);
                        state <= DIV;
                    end
                end
                DIV: begin
                    // a_r doubles as the quotient shift register: dividend
                    // bits leave at the top while quotient bits enter below.
                    rem <= rem_nx;
                    a_r <= {a_r[N-2:0], ge};
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        q     <= {a_r[N-2:0], ge};
                        dz    <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/loba_div_16_4.md
LOBA_DIV_16_4 -- requirements
Module: loba_div_16_4

Interface
REQ-001 SHALL have parameter N, default 16, the operand and quotient width.
REQ-002 SHALL have parameter K, default 4, the number of divisor bits kept from the leading one downward.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the request operands are valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-007 SHALL have port a, input, N bits: unsigned dividend.
REQ-008 SHALL have port b, input, N bits: unsigned divisor.
REQ-009 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have port q, output, N bits: approximate quotient.
REQ-012 SHALL have port dz, output, 1 bit: divide-by-zero flag, qualified by out_valid.

Function
REQ-013 SHALL implement the FSM states IDLE, SPLIT, DIV and DONE.
REQ-014 SHALL drive in_ready high only in IDLE and out_valid high only in DONE, both decoded directly from state.
REQ-015 SHALL capture a and b into internal registers when in_valid and in_ready are both high, and move IDLE->SPLIT.
REQ-016 SHALL ignore a, b and in_valid in every state other than IDLE.
REQ-017 In SPLIT, SHALL set kb to the leading-one index of the captured b (0..N-1).
REQ-018 In SPLIT, SHALL set the truncated divisor bt to b with bits [kb-K:0] cleared when kb>=K, and to b unchanged when kb<K.
REQ-019 In SPLIT, if b==0, SHALL set q=all-ones and dz=1 and go to DONE; otherwise SHALL clear the remainder, load iteration counter=N-1 and go to DIV.
REQ-020 In DIV, SHALL perform one restoring shift-subtract step per cycle, MSB of a first, using an N+1-bit remainder against bt, and write one quotient bit per cycle.
REQ-021 SHALL go DIV->DONE on the cycle the counter is 0 (N iterations total), with q=floor(a/bt) and dz=0.
REQ-022 SHALL assert out_valid N+1 rising edges after the accepting edge (17 for N=16), and 1 edge after it for b==0.
REQ-023 In DONE, SHALL hold q and dz stable while out_ready is low, for unbounded back-pressure.
REQ-024 SHALL go DONE->IDLE on out_valid && out_ready, with in_ready high in the next cycle; no request is accepted in the same cycle as the result handoff.
REQ-025 SHALL leave q and dz unchanged outside DONE; only SPLIT and DIV update them.
REQ-026 SHALL compute exactly (bt==b) whenever b < 2^K or all bits of b below kb-K+1 are zero.

Reset
REQ-027 While rst_n is low, SHALL force state=IDLE, in_ready=1, out_valid=0, q=0, dz=0, and clear the counter and operand registers.
REQ-028 On rst_n assertion mid-operation (SPLIT/DIV/DONE), SHALL abort immediately with no out_valid pulse; the first request after release SHALL produce a correct result.

Verification
REQ-029 Bench SHALL cover: a=1000, b=10 (kb=3, bt=10) -> out_valid 17 edges after accept, q=100, dz=0.
REQ-030 Bench SHALL cover: a=60000, b=300 (kb=8, bt=288) -> q=208, dz=0.
REQ-031 Bench SHALL cover: a=65535, b=1 -> q=65535; and a=5, b=0 -> out_valid 1 edge after accept, q=16'hFFFF, dz=1.
REQ-032 Bench SHALL cover: out_ready held low 5 cycles in DONE -> q/dz stable, in_ready=0, and an in_valid pulse during the hold is ignored; then out_ready=1 -> IDLE the next cycle.
REQ-033 Bench SHALL cover: rst_n pulsed low at iteration 8 of DIV -> outputs at reset values immediately, no out_valid; a=1000, b=10 issued afterwards -> q=100.
REQ-034 Bench SHALL cover: 1000 random (a,b) pairs with random out_ready -> q equals the floor(a/bt) reference model, dz==(b==0), and exactly one result per accepted request.
